blvds_link_ctrl: RTL and testbench

BLVDS_LINK_CTRL -- requirements
Module: blvds_link_ctrl

---
 rtl/blvds_link_pkg.sv | 33 +++
 rtl/blvds_bit_timer.sv | 55 +++++
 rtl/blvds_link_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_blvds_link_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blvds_link_pkg.sv
// Shared definitions for the half-duplex BLVDS link controller: FSM encoding,
// bit-timer modes and frame/timing defaults.
package blvds_link_pkg;

   localparam int FRAME_BITS       = 10;
   localparam int DATA_BITS        = 8;
   localparam int DEF_CLKS_PER_BIT = 4;
   localparam int DEF_GUARD_CYCLES = 2;
   localparam int TIMER_W          = 8;
   localparam int BIT_CNT_W        = 4;

   typedef enum logic [2:0] {
      IDLE,
      TX_GUARD,
      TX_SHIFT,
      TX_RELEASE,
      RX_START,
      RX_SHIFT,
      RX_STOP
   } link_state_t;

   typedef enum logic [1:0] {
      TMR_HALF,
      TMR_BIT,
      TMR_GUARD
   } timer_mode_t;

   // The bus is only ever driven while the guard or the frame itself is going out.
   function automatic logic drives_bus(input link_state_t s);
      return (s == TX_GUARD) || (s == TX_SHIFT);
   endfunction

endpackage

// File: rtl/blvds_bit_timer.sv
// Loadable down-counter timing half-bit, full-bit and guard intervals.
// A strobe is high during the last cycle of the interval that was loaded.
module blvds_bit_timer
   import blvds_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  timer_mode_t load_mode,
   output logic        half_done,
   output logic        bit_done,
   output logic        guard_done
);

   localparam logic [TIMER_W-1:0] HALF_LOAD  = TIMER_W'(CLKS_PER_BIT / 2);
   localparam logic [TIMER_W-1:0] BIT_LOAD   = TIMER_W'(CLKS_PER_BIT);
   localparam logic [TIMER_W-1:0] GUARD_LOAD = TIMER_W'(GUARD_CYCLES);

   logic [TIMER_W-1:0] count;
   logic [TIMER_W-1:0] load_value;
   timer_mode_t        mode_q;
   logic               expiring;

   always_comb begin
      load_value = BIT_LOAD;
      case (load_mode)
         TMR_HALF:  load_value = HALF_LOAD;
         TMR_BIT:   load_value = BIT_LOAD;
         TMR_GUARD: load_value = GUARD_LOAD;
         default:   load_value = BIT_LOAD;
      endcase
   end

   // Counts down to zero and parks there, so a strobe fires once per load.
   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         mode_q <= TMR_BIT;
      end else if (load) begin
         count  <= load_value;
         mode_q <= load_mode;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expiring   = (count == TIMER_W'(1));
   assign half_done  = expiring && (mode_q == TMR_HALF);
   assign bit_done   = expiring && (mode_q == TMR_BIT);
   assign guard_done = expiring && (mode_q == TMR_GUARD);

endmodule

// File: rtl/blvds_link_ctrl.sv
// Half-duplex UART-style link over a single bidirectional BLVDS buffer:
// input synchronizer, link FSM, transmit/receive shift registers.
module blvds_link_ctrl
   import blvds_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 busy,
   output logic                 buf_i,
   output logic                 buf_t,
   input  logic                 buf_o
);

   localparam logic [BIT_CNT_W-1:0] LAST_TX_BIT = BIT_CNT_W'(FRAME_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_RX_BIT = BIT_CNT_W'(DATA_BITS - 1);

   link_state_t           state;
   link_state_t           state_next;
   logic                  sync_meta;
   logic                  rxs;
   logic [FRAME_BITS-1:0] tx_shift;
   logic [DATA_BITS-1:0]  rx_shift;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  stop_wait;
   logic                  tx_accept;
   logic                  tx_last_bit;
   logic                  timer_load;
   timer_mode_t           timer_mode;
   logic                  half_done;
   logic                  bit_done;
   logic                  guard_done;

   blvds_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) u_bit_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_mode  (timer_mode),
      .half_done  (half_done),
      .bit_done   (bit_done),
      .guard_done (guard_done)
   );

   // buf_o is asynchronous; flops reset to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b1;
         rxs       <= 1'b1;
      end else begin
         sync_meta <= buf_o;
         rxs       <= sync_meta;
      end
   end

   assign tx_accept   = (state == IDLE) && rxs && tx_valid && tx_ready;
   assign tx_last_bit = (bit_cnt == LAST_TX_BIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A falling line in IDLE always wins: tx_ready has already dropped for it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!rxs) begin
               state_next = RX_START;
            end else if (tx_accept) begin
               state_next = TX_GUARD;
            end
         end
         TX_GUARD: begin
            if (guard_done) begin
               state_next = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (bit_done && tx_last_bit) begin
               state_next = TX_RELEASE;
            end
         end
         TX_RELEASE: begin
            if (guard_done) begin
               state_next = IDLE;
            end
         end
         RX_START: begin
            if (half_done) begin
               state_next = rxs ? IDLE : RX_SHIFT;
            end
         end
         RX_SHIFT: begin
            if (bit_done && (bit_cnt == LAST_RX_BIT)) begin
               state_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (stop_wait) begin
               if (rxs) begin
                  state_next = IDLE;
               end
            end else if (bit_done && rxs) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      buf_t      = !drives_bus(state);
      buf_i      = (state == TX_SHIFT) ? tx_shift[0] : 1'b1;
      timer_load = 1'b0;
      timer_mode = TMR_BIT;
      case (state)
         IDLE: begin
            if (!rxs) begin
               timer_load = 1'b1;
               timer_mode = TMR_HALF;
            end else if (tx_accept) begin
               timer_load = 1'b1;
               timer_mode = TMR_GUARD;
            end
         end
         TX_GUARD: begin
            timer_load = guard_done;
            timer_mode = TMR_BIT;
         end
         TX_SHIFT: begin
            timer_load = bit_done;
            timer_mode = tx_last_bit ? TMR_GUARD : TMR_BIT;
         end
         RX_START: begin
            timer_load = half_done && !rxs;
            timer_mode = TMR_BIT;
         end
         RX_SHIFT: begin
            timer_load = bit_done;
            timer_mode = TMR_BIT;
         end
         default: begin
            timer_load = 1'b0;
            timer_mode = TMR_BIT;
         end
      endcase
   end

   // tx_ready looks one cycle ahead (next state, next rxs) so it is registered
   // yet never high outside IDLE or while the line is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_ready     <= 1'b0;
         tx_shift     <= '1;
         rx_shift     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         bit_cnt      <= '0;
         stop_wait    <= 1'b0;
      end else begin
         tx_ready     <= (state_next == IDLE) && sync_meta;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt   <= '0;
               stop_wait <= 1'b0;
               if (tx_accept) begin
                  tx_shift <= {1'b1, tx_data, 1'b0};
               end
            end
            TX_SHIFT: begin
               if (bit_done) begin
                  tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
                  bit_cnt  <= bit_cnt + 1'b1;
               end
            end
            RX_SHIFT: begin
               if (bit_done) begin
                  rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                  bit_cnt  <= bit_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (!stop_wait && bit_done) begin
                  if (rxs) begin
                     rx_data  <= rx_shift;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_frame_err <= 1'b1;
                     stop_wait    <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blvds_link_ctrl.sv
// Bench for blvds_link_ctrl: wired-AND bus shared with a remote node model,
// per-frame expectations computed from the frame format.
module tb_blvds_link_ctrl;

   localparam int CPB     = 4;
   localparam int G       = 2;
   localparam int TX_LOW  = G + 10 * CPB;
   localparam int TX_BUSY = 2 * G + 10 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       busy;
   logic       buf_i;
   logic       buf_t;
   logic       buf_o;
   logic       remote_drive = 1'b1;
   wire        bus_line;

   int         checks = 0;
   int         errors = 0;
   int         cycle = 0;
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         both_cnt = 0;
   int         buft_low_cnt = 0;
   int         last_valid_cycle = 0;
   int         accept_cycle = 0;
   logic [7:0] last_rx = 8'h00;
   logic [7:0] model_rx_data = 8'h00;

   assign bus_line = (buf_t ? 1'b1 : buf_i) & remote_drive;
   assign buf_o    = bus_line;

   blvds_link_ctrl #(
      .CLKS_PER_BIT (CPB),
      .GUARD_CYCLES (G)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .busy         (busy),
      .buf_i        (buf_i),
      .buf_t        (buf_t),
      .buf_o        (buf_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         valid_cnt++;
         last_rx = rx_data;
         last_valid_cycle = cycle;
      end
      if (rx_frame_err === 1'b1) err_cnt++;
      if (rx_valid === 1'b1 && rx_frame_err === 1'b1) both_cnt++;
      if (buf_t === 1'b0) buft_low_cnt++;
   end

   // Expected level on the line c cycles after acceptance: guard high, then
   // start 0, data LSB first, stop 1, each bit CPB cycles long.
   function automatic logic exp_line(input logic [7:0] b, input int c);
      int idx;
      if (c < G) return 1'b1;
      idx = (c - G) / CPB;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[3'(idx - 1)];
      return 1'b1;
   endfunction

   task automatic remote_send(input logic [7:0] b, input logic stop_bit, input int extra_low);
      remote_drive = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         remote_drive = b[i];
         repeat (CPB) @(negedge clk);
      end
      remote_drive = stop_bit;
      repeat (CPB) @(negedge clk);
      if (!stop_bit) repeat (extra_low) @(negedge clk);
      remote_drive = 1'b1;
   endtask

   task automatic test_tx_frame(input logic [7:0] b, input bit set_valid);
      int   w;
      int   low_run;
      int   busy_run;
      int   wave_bad;
      int   v0;
      int   e0;
      bit   low_open;
      bit   busy_open;
      if (set_valid) begin
         tx_data  = b;
         tx_valid = 1'b1;
      end
      w = 0;
      while (tx_ready !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (w >= 300) begin
         errors++;
         $display("[TB] FAIL tx_accept_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, w);
         tx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      accept_cycle = cycle;
      tx_valid     = 1'b0;
      v0 = valid_cnt;
      e0 = err_cnt;
      low_run = 0; busy_run = 0; wave_bad = 0; low_open = 1'b1; busy_open = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (low_open && buf_t === 1'b0) low_run++; else low_open = 1'b0;
         if (busy_open && busy === 1'b1) busy_run++; else busy_open = 1'b0;
         if (c < TX_LOW && buf_i !== exp_line(b, c)) wave_bad++;
      end
      checks++;
      if (low_run != TX_LOW) begin
         errors++;
         $display("[TB] FAIL tx_buf_t_low byte=%h: got %0d cycles, required %0d", b, low_run, TX_LOW);
      end
      checks++;
      if (busy_run != TX_BUSY) begin
         errors++;
         $display("[TB] FAIL tx_busy_len byte=%h: got %0d cycles, required %0d", b, busy_run, TX_BUSY);
      end
      checks++;
      if (wave_bad != 0) begin
         errors++;
         $display("[TB] FAIL tx_waveform byte=%h: got %0d wrong cycles, required 0", b, wave_bad);
      end
      checks++;
      if (valid_cnt != v0 || err_cnt != e0) begin
         errors++;
         $display("[TB] FAIL tx_self_rx byte=%h: got %0d/%0d rx pulses, required 0/0", b, valid_cnt - v0, err_cnt - e0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (buf_t !== 1'b1) begin errors++; $display("[TB] FAIL reset_buf_t: got %b required 1", buf_t); end
      checks++;
      if (buf_i !== 1'b1) begin errors++; $display("[TB] FAIL reset_buf_i: got %b required 1", buf_i); end
      checks++;
      if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b required 0", tx_ready); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
      checks++;
      if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_pulses: got valid=%b err=%b required 0/0", rx_valid, rx_frame_err);
      end
      checks++;
      if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %h required 00", rx_data); end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_latency: got %b required 1", tx_ready); end
      model_rx_data = 8'h00;
   endtask

   task automatic test_tx();
      logic [7:0] bytes [3];
      bytes[0] = 8'hA5;
      bytes[1] = 8'($urandom);
      bytes[2] = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
         test_tx_frame(bytes[i], 1'b1);
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic test_rx();
      logic [7:0] b;
      int v0, e0, t0;
      for (int i = 0; i < 4; i++) begin
         b  = (i == 0) ? 8'h3C : 8'($urandom);
         v0 = valid_cnt; e0 = err_cnt; t0 = buft_low_cnt;
         remote_send(b, 1'b1, 0);
         repeat (10) @(negedge clk);
         model_rx_data = b;
         checks++;
         if (valid_cnt != v0 + 1) begin
            errors++;
            $display("[TB] FAIL rx_valid_count byte=%h: got %0d pulses required 1", b, valid_cnt - v0);
         end
         checks++;
         if (last_rx !== b) begin errors++; $display("[TB] FAIL rx_data: got %h required %h", last_rx, b); end
         checks++;
         if (err_cnt != e0) begin errors++; $display("[TB] FAIL rx_no_err byte=%h: got %0d required 0", b, err_cnt - e0); end
         checks++;
         if (buft_low_cnt != t0) begin
            errors++;
            $display("[TB] FAIL rx_buf_t byte=%h: got %0d driven cycles required 0", b, buft_low_cnt - t0);
         end
         checks++;
         if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rx_idle_after byte=%h: got busy=%b required 0", b, busy); end
      end
   endtask

   task automatic test_glitch();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      remote_drive = 1'b0;
      @(negedge clk);
      remote_drive = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (valid_cnt != v0 || err_cnt != e0) begin
         errors++;
         $display("[TB] FAIL glitch_pulses: got %0d/%0d required 0/0", valid_cnt - v0, err_cnt - e0);
      end
      checks++;
      if (busy !== 1'b0 || tx_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL glitch_idle: got busy=%b tx_ready=%b required 0/1", busy, tx_ready);
      end
   endtask

   task automatic test_frame_error();
      logic [7:0] b;
      int v0, e0;
      b  = 8'($urandom);
      v0 = valid_cnt; e0 = err_cnt;
      remote_send(b, 1'b0, 8);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ferr_wait_low: got busy=%b required 1", busy); end
      repeat (10) @(negedge clk);
      checks++;
      if (err_cnt != e0 + 1) begin errors++; $display("[TB] FAIL ferr_count: got %0d required 1", err_cnt - e0); end
      checks++;
      if (valid_cnt != v0) begin errors++; $display("[TB] FAIL ferr_no_valid: got %0d required 0", valid_cnt - v0); end
      checks++;
      if (rx_data !== model_rx_data) begin
         errors++;
         $display("[TB] FAIL ferr_rx_data_kept: got %h required %h", rx_data, model_rx_data);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ferr_idle_after: got busy=%b required 0", busy); end
   endtask

   task automatic test_contention();
      int v0;
      v0 = valid_cnt;
      fork
         remote_send(8'hC3, 1'b1, 0);
         begin
            repeat (2) @(negedge clk);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            test_tx_frame(8'h55, 1'b0);
         end
      join
      model_rx_data = 8'hC3;
      checks++;
      if (valid_cnt != v0 + 1 || last_rx !== 8'hC3) begin
         errors++;
         $display("[TB] FAIL contention_rx: got %0d pulses data %h required 1 pulse data c3", valid_cnt - v0, last_rx);
      end
      checks++;
      if (accept_cycle <= last_valid_cycle) begin
         errors++;
         $display("[TB] FAIL contention_order: got accept cycle %0d rx_valid cycle %0d required accept later", accept_cycle, last_valid_cycle);
      end
   endtask

   task automatic test_reset_mid_tx();
      int w;
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      w = 0;
      while (tx_ready !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      checks++;
      if (buf_t !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_driving: got buf_t=%b required 0", buf_t); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (buf_t !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_mid_release: got buf_t=%b busy=%b required 1/0", buf_t, busy);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (valid_cnt != v0 || err_cnt != e0) begin
         errors++;
         $display("[TB] FAIL rst_mid_pulses: got %0d/%0d required 0/0", valid_cnt - v0, err_cnt - e0);
      end
      model_rx_data = 8'h00;
      checks++;
      if (rx_data !== model_rx_data) begin errors++; $display("[TB] FAIL rst_mid_rx_data: got %h required 00", rx_data); end
      test_tx_frame(8'($urandom), 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] blvds_link_ctrl bench, CLKS_PER_BIT=%0d GUARD_CYCLES=%0d", CPB, G);
      test_reset();
      test_tx();
      test_rx();
      test_glitch();
      test_frame_error();
      test_contention();
      test_reset_mid_tx();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("[TB] FAIL pulse_exclusive: got %0d overlapping cycles required 0", both_cnt);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
